// File: rtl/arith_cmd_sequencer.sv
// Command sequencer feeding the new_arithmetic stage: gathers opcode/A/B bytes, issues one
// enable cycle, captures the selected demux lane. Optional macro: ARITH_SEQ_ZERO_GUARD_EN.
module arith_cmd_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [1:0]  sel,
  output logic        el,
  input  logic [15:0] y1,
  input  logic [15:0] y2,
  input  logic [15:0] y3,
  input  logic [15:0] y4,
  output logic [15:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET_A = 3'd1,
    S_GET_B = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic        accept;
  logic        op_legal;
  logic        guard_on_b;
  logic        guard_now;
  logic [15:0] lane;

  assign accept   = in_valid && in_ready;
  assign op_legal = (in_data[7:2] == 6'd0);

`ifdef ARITH_SEQ_ZERO_GUARD_EN
  // guard_on_b looks at the incoming B byte so el can be suppressed for the ISSUE cycle itself
  assign guard_on_b = (sel == 2'b11) && (in_data == 8'd0);
  assign guard_now  = (sel == 2'b11) && (B == 8'd0);
`else
  assign guard_on_b = 1'b0;
  assign guard_now  = 1'b0;
`endif

  always_comb begin
    lane = y1;
    case (sel)
      2'b00: lane = y1;
      2'b01: lane = y2;
      2'b10: lane = y3;
      2'b11: lane = y4;
      default: lane = y1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && op_legal) state_next = S_GET_A;
      S_GET_A: if (accept) state_next = S_GET_B;
      S_GET_B: if (accept) state_next = S_ISSUE;
      S_ISSUE: state_next = S_DONE;
      S_DONE:  if (res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE) || (state == S_GET_A) || (state == S_GET_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A         <= 8'd0;
      B         <= 8'd0;
      sel       <= 2'd0;
      el        <= 1'b1;
      res_data  <= 16'd0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      el <= 1'b1;
      case (state)
        S_IDLE:  if (accept && op_legal) sel <= in_data[1:0];
        S_GET_A: if (accept) A <= in_data;
        S_GET_B: if (accept) begin
          B  <= in_data;
          el <= guard_on_b;
        end
        S_ISSUE: begin
          res_data  <= guard_now ? 16'hFFFF : lane;
          res_err   <= guard_now;
          res_valid <= 1'b1;
        end
        S_DONE:  if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_cmd_sequencer.sv
// Directed self-checking bench for arith_cmd_sequencer with constant lane stubs on y1..y4.
module tb_arith_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A, B;
  logic [1:0]  sel;
  logic        el;
  logic [15:0] y1, y2, y3, y4;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        res_err;

  int n_checks = 0;
  int n_pass   = 0;
  int el_lows  = 0;

  arith_cmd_sequencer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .el(el),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .res_err(res_err)
  );

  always #5 clk = ~clk;

  assign y1 = 16'h1111;
  assign y2 = 16'h2222;
  assign y3 = 16'h3333;
  assign y4 = 16'h4444;

  always @(negedge clk) if (!el) el_lows++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] d);
    check_eq("in_ready_before_byte", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [15:0] lane_exp [4];
  logic [7:0]  stream [6];

  initial begin
    int base, idx, b0, b1, rv0, rv1, nr_lows, cyc;
    logic acc;
    logic [15:0] d0, d1;
    lane_exp[0] = 16'h1111; lane_exp[1] = 16'h2222;
    lane_exp[2] = 16'h3333; lane_exp[3] = 16'h4444;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0;
    #22;
    check_eq("rst_el", el, 1);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_res_err", res_err, 0);
    check_eq("rst_A", A, 0);
    check_eq("rst_B", B, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_res_data", res_data, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_in_ready", in_ready, 1);

    // Reset in the middle of a command
    send_byte(8'h00);
    send_byte(8'h05);
    check_eq("midcmd_A_latched", A, 8'h05);
    #2 rst = 1'b1; #1;
    check_eq("midrst_A", A, 0);
    check_eq("midrst_el", el, 1);
    check_eq("midrst_res_valid", res_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Lane capture for each select value, with backpressure on the first
    for (int s = 0; s < 4; s++) begin
      base = el_lows;
      send_byte({6'd0, s[1:0]});
      send_byte(8'h12);
      send_byte(8'h34);
      check_eq("issue_el_low", el, 0);
      check_eq("issue_in_ready", in_ready, 0);
      check_eq("issue_res_valid", res_valid, 0);
      @(posedge clk); #1;
      check_eq("done_res_valid", res_valid, 1);
      check_eq("lane_res_data", res_data, lane_exp[s]);
      check_eq("lane_res_err", res_err, 0);
      check_eq("done_el_high", el, 1);
      check_eq("cmd_A", A, 8'h12);
      check_eq("cmd_B", B, 8'h34);
      if (s == 0) begin
        for (int k = 0; k < 10; k++) begin
          @(posedge clk); #1;
          check_eq("bp_res_valid", res_valid, 1);
          check_eq("bp_res_data", res_data, 16'h1111);
          check_eq("bp_in_ready", in_ready, 0);
        end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check_eq("hs_res_valid_low", res_valid, 0);
      check_eq("hs_in_ready", in_ready, 1);
      check_eq("hs_res_data_held", res_data, lane_exp[s]);
      check_eq("el_low_once", el_lows - base, 1);
    end

    // Illegal opcode is swallowed; the following byte becomes the opcode
    base = el_lows;
    send_byte(8'h84);
    check_eq("illegal_sel_unchanged", sel, 2'b11);
    check_eq("illegal_el", el, 1);
    send_byte(8'h01);
    check_eq("after_illegal_sel", sel, 2'b01);
    send_byte(8'h00);
    send_byte(8'h00);
    check_eq("illegal_issue_el", el, 0);
    @(posedge clk); #1;
    check_eq("after_illegal_res", res_data, 16'h2222);
    check_eq("illegal_el_count", el_lows - base, 1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Back-to-back: two commands streamed with res_ready held high
    stream[0] = 8'h00; stream[1] = 8'hAA; stream[2] = 8'hBB;
    stream[3] = 8'h02; stream[4] = 8'hCC; stream[5] = 8'hDD;
    idx = 0; b0 = -1; b1 = -1; rv0 = -1; rv1 = -1; nr_lows = 0; cyc = 0;
    d0 = 16'h0; d1 = 16'h0;
    base = el_lows;
    res_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 6);
      in_data  = (idx < 6) ? stream[idx] : 8'h00;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (idx == 2) b0 = cyc;
        if (idx == 5) b1 = cyc;
        idx++;
      end
      if (!in_ready) nr_lows++;
      if (res_valid && rv0 < 0) begin rv0 = cyc; d0 = res_data; end
      else if (res_valid && rv0 >= 0 && cyc > rv0 + 1 && rv1 < 0) begin rv1 = cyc; d1 = res_data; end
    end
    in_valid = 1'b0;
    res_ready = 1'b0;
    check_eq("b2b_first_latency", rv0 - b0, 1);
    check_eq("b2b_period", b1 - b0, 5);
    check_eq("b2b_second_latency", rv1 - b1, 1);
    check_eq("b2b_first_data", d0, 16'h1111);
    check_eq("b2b_second_data", d1, 16'h3333);
    check_eq("b2b_not_ready_cycles", nr_lows, 4);
    check_eq("b2b_el_pulses", el_lows - base, 2);

    // Divide by zero
    base = el_lows;
    send_byte(8'h03);
    send_byte(8'h10);
    send_byte(8'h00);
`ifdef ARITH_SEQ_ZERO_GUARD_EN
    check_eq("dz_issue_el", el, 1);
    @(posedge clk); #1;
    check_eq("dz_res_data", res_data, 16'hFFFF);
    check_eq("dz_res_err", res_err, 1);
    check_eq("dz_el_count", el_lows - base, 0);
`else
    check_eq("dz_issue_el", el, 0);
    @(posedge clk); #1;
    check_eq("dz_res_data", res_data, 16'h4444);
    check_eq("dz_res_err", res_err, 0);
    check_eq("dz_el_count", el_lows - base, 1);
`endif
    check_eq("dz_res_valid", res_valid, 1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_eq("dz_release", res_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
